// File: rtl/aes_host_if.sv
// aes_host_if: host-side initiator for the AES round-sequencing core.
// Accepts one block request per handshake, starts the core, captures the four
// result columns during the final round and returns them on a response
// channel. A watchdog aborts an operation that never signals done.
module aes_host_if #(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_mode,
   input  logic         req_enc_dec,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [127:0] resp_data,
   output logic         resp_err,
   output logic [1:0]   core_mode,
   output logic         core_enc_dec,
   output logic [3:0]   core_round_amount,
   output logic         core_start,
   output logic         core_abort,
   input  logic [3:0]   core_round,
   input  logic [1:0]   core_radix_sel,
   input  logic         core_done,
   input  logic [31:0]  core_col_in
);

   // Last watchdog value that still allows one more BUSY cycle.
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e           state_q,     state_d;
   logic [1:0]       mode_q,      mode_d;
   logic             enc_dec_q,   enc_dec_d;
   logic [3:0]       round_amt_q, round_amt_d;
   logic [3:0][31:0] col_q,       col_d;
   logic [15:0]      wd_q,        wd_d;
   logic             err_q,       err_d;
   logic             abort_q,     abort_d;

   // Next-state, capture and watchdog logic.
   always_comb begin
      // NOTE: every _d is given its hold value first, so no branch of the case can infer a latch.
      state_d     = state_q;
      mode_d      = mode_q;
      enc_dec_d   = enc_dec_q;
      round_amt_d = round_amt_q;
      col_d       = col_q;
      wd_d        = wd_q;
      err_d       = err_q;
      abort_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               mode_d    = req_mode;
               enc_dec_d = req_enc_dec;
               case (req_mode)
                  2'b00:   round_amt_d = 4'd10;
                  2'b01:   round_amt_d = 4'd12;
                  2'b10:   round_amt_d = 4'd14;
                  default: round_amt_d = 4'd0;
               endcase
               if (req_mode == 2'b11) begin
                  // Illegal key size: answer with an error, never start the core.
                  err_d   = 1'b1;
                  col_d   = '0;
                  state_d = RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = START;
               end
            end
         end

         START: begin
            col_d   = '0;
            wd_d    = '0;
            state_d = BUSY;
         end

         BUSY: begin
            if (wd_q != 16'hFFFF) begin
               wd_d = wd_q + 16'd1;
            end
            if (core_done) begin
               // Done wins over a coincident timeout; the last beat lands in slot 3.
               col_d[3] = core_col_in;
               err_d    = 1'b0;
               state_d  = RESP;
            end else begin
               if (core_round == round_amt_q) begin
                  col_d[core_radix_sel] = core_col_in;
               end
               if (wd_q >= WD_LAST) begin
                  abort_d = 1'b1;
                  err_d   = 1'b1;
                  col_d   = '0;
                  state_d = RESP;
               end
            end
         end

         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         mode_q      <= '0;
         enc_dec_q   <= 1'b0;
         round_amt_q <= '0;
         // NOTE: the column store is reset too, so data from an interrupted operation never reappears.
         col_q       <= '0;
         wd_q        <= '0;
         err_q       <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
         state_q     <= state_d;
         mode_q      <= mode_d;
         enc_dec_q   <= enc_dec_d;
         round_amt_q <= round_amt_d;
         col_q       <= col_d;
         wd_q        <= wd_d;
         err_q       <= err_d;
         abort_q     <= abort_d;
      end
   end

   assign req_ready         = (state_q == IDLE);
   assign resp_valid        = (state_q == RESP);
   assign core_start        = (state_q == START);
   assign core_abort        = abort_q;
   assign resp_err          = err_q;
   assign core_mode         = mode_q;
   assign core_enc_dec      = enc_dec_q;
   assign core_round_amount = round_amt_q;
   assign resp_data         = {col_q[0], col_q[1], col_q[2], col_q[3]};

endmodule

// File: tb/tb_aes_host_if.sv
// tb_aes_host_if: directed bench for aes_host_if with a behavioural core model.
// A second instance with a short watchdog covers the timeout path.
module tb_aes_host_if;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;

   logic         req_valid = 1'b0;
   logic [1:0]   req_mode = 2'b00;
   logic         req_enc_dec = 1'b0;
   logic         resp_ready = 1'b0;
   logic [3:0]   core_round = 4'd0;
   logic [1:0]   core_radix_sel = 2'd0;
   logic         core_done = 1'b0;
   logic [31:0]  core_col_in = 32'd0;
   logic         req_ready, resp_valid, resp_err, core_enc_dec, core_start, core_abort;
   logic [127:0] resp_data;
   logic [1:0]   core_mode;
   logic [3:0]   core_round_amount;

   logic         t_req_valid = 1'b0;
   logic [1:0]   t_req_mode = 2'b00;
   logic         t_resp_ready = 1'b0;
   logic [3:0]   t_core_round = 4'd0;
   logic [1:0]   t_core_radix_sel = 2'd0;
   logic [31:0]  t_core_col_in = 32'd0;
   logic         t_req_ready, t_resp_valid, t_resp_err, t_core_enc_dec, t_core_start, t_core_abort;
   logic [127:0] t_resp_data;
   logic [1:0]   t_core_mode;
   logic [3:0]   t_core_round_amount;

   int n_checks = 0;
   int n_fail = 0;
   int start_cnt = 0;
   int abort_cnt = 0;

   always #5 clk = ~clk;

   aes_host_if dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_enc_dec(req_enc_dec),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
      .core_mode(core_mode), .core_enc_dec(core_enc_dec), .core_round_amount(core_round_amount),
      .core_start(core_start), .core_abort(core_abort),
      .core_round(core_round), .core_radix_sel(core_radix_sel), .core_done(core_done),
      .core_col_in(core_col_in)
   );

   aes_host_if #(.TIMEOUT_CYCLES(20)) dut_to (
      .clk(clk), .reset_n(reset_n),
      .req_valid(t_req_valid), .req_ready(t_req_ready), .req_mode(t_req_mode), .req_enc_dec(1'b0),
      .resp_valid(t_resp_valid), .resp_ready(t_resp_ready), .resp_data(t_resp_data), .resp_err(t_resp_err),
      .core_mode(t_core_mode), .core_enc_dec(t_core_enc_dec), .core_round_amount(t_core_round_amount),
      .core_start(t_core_start), .core_abort(t_core_abort),
      .core_round(t_core_round), .core_radix_sel(t_core_radix_sel), .core_done(1'b0),
      .core_col_in(t_core_col_in)
   );

   // Count start and abort pulses of the main instance, sampled mid-cycle.
   always @(negedge clk) begin
      if (core_start) start_cnt++;
      if (core_abort) abort_cnt++;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Behavioural core: optional key-schedule beats, then rounds 0..ra with four
   // column beats each; col = base + 16*round + beat. With dup, a bogus slot-2
   // beat precedes the final round so the later real beat must overwrite it.
   task automatic drive_core(input int ra, input logic [31:0] base, input int ks, input bit dup);
      for (int i = 0; i < ks; i++) begin
         core_round     = 4'd0;
         core_radix_sel = 2'(i);
         core_col_in    = 32'hDEAD0000 + 32'(i);
         core_done      = 1'b0;
         cycle();
      end
      for (int r = 0; r <= ra; r++) begin
         if (dup && r == ra) begin
            core_round     = 4'(r);
            core_radix_sel = 2'd2;
            core_col_in    = 32'h0BADF00D;
            core_done      = 1'b0;
            cycle();
         end
         for (int b = 0; b < 4; b++) begin
            core_round     = 4'(r);
            core_radix_sel = 2'(b);
            core_col_in    = base + 32'(16 * r + b);
            core_done      = (r == ra) && (b == 3);
            if (core_done) check("resp_not_early", resp_valid, 1'b0);
            cycle();
         end
      end
      core_done      = 1'b0;
      core_round     = 4'd0;
      core_radix_sel = 2'd0;
      core_col_in    = 32'd0;
   endtask

   task automatic finish_resp();
      resp_ready = 1'b1;
      cycle();
      resp_ready = 1'b0;
      check("hs_valid_low", resp_valid, 1'b0);
      check("hs_req_ready", req_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int s0;
      int n;
      int hi;

      // Reset values.
      cycle();
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_core_start", core_start, 1'b0);
      check("rst_resp_data", resp_data, 128'd0);
      check("rst_round_amt", core_round_amount, 4'd0);
      @(negedge clk);
      reset_n = 1'b1;
      cycle();

      // 1: AES-128 encrypt.
      s0 = start_cnt;
      req_valid = 1'b1; req_mode = 2'b00; req_enc_dec = 1'b0;
      check("t1_req_ready", req_ready, 1'b1);
      cycle();
      req_valid = 1'b0;
      check("t1_start_pulse", core_start, 1'b1);
      check("t1_round_amt", core_round_amount, 4'd10);
      check("t1_core_mode", core_mode, 2'b00);
      cycle();
      check("t1_start_low", core_start, 1'b0);
      drive_core(10, 32'hA0000000, 0, 1'b0);
      check("t1_latency_valid", resp_valid, 1'b1);
      check("t1_data", resp_data, 128'hA00000A0_A00000A1_A00000A2_A00000A3);
      check("t1_err", resp_err, 1'b0);
      check("t1_one_start", start_cnt - s0, 1);
      finish_resp();

      // 2: AES-256 decrypt with key schedule, round-0 beats and a repeated final beat.
      req_valid = 1'b1; req_mode = 2'b10; req_enc_dec = 1'b1;
      cycle();
      req_valid = 1'b0;
      check("t2_round_amt", core_round_amount, 4'd14);
      check("t2_enc_dec", core_enc_dec, 1'b1);
      cycle();
      drive_core(14, 32'hB0000000, 6, 1'b1);
      check("t2_valid", resp_valid, 1'b1);
      check("t2_data", resp_data, 128'hB00000E0_B00000E1_B00000E2_B00000E3);
      check("t2_err", resp_err, 1'b0);
      finish_resp();

      // 3: illegal mode.
      s0 = start_cnt;
      req_valid = 1'b1; req_mode = 2'b11; req_enc_dec = 1'b0;
      cycle();
      req_valid = 1'b0;
      check("t3_valid", resp_valid, 1'b1);
      check("t3_err", resp_err, 1'b1);
      check("t3_data", resp_data, 128'd0);
      check("t3_round_amt", core_round_amount, 4'd0);
      check("t3_no_start", start_cnt - s0, 0);
      finish_resp();

      // 4: backpressure, then a back-to-back AES-192 request.
      req_valid = 1'b1; req_mode = 2'b00; req_enc_dec = 1'b0;
      cycle();
      req_valid = 1'b0;
      cycle();
      drive_core(10, 32'hD0000000, 0, 1'b0);
      req_valid = 1'b1; req_mode = 2'b01;
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_data", resp_data, 128'hD00000A0_D00000A1_D00000A2_D00000A3);
         check("t4_hold_valid", resp_valid, 1'b1);
         check("t4_req_blocked", req_ready, 1'b0);
         cycle();
      end
      resp_ready = 1'b1;
      cycle();
      resp_ready = 1'b0;
      check("t4_after_hs_valid", resp_valid, 1'b0);
      check("t4_after_hs_ready", req_ready, 1'b1);
      cycle();
      req_valid = 1'b0;
      check("t4_b2b_start", core_start, 1'b1);
      check("t4_b2b_round_amt", core_round_amount, 4'd12);
      cycle();
      drive_core(12, 32'hC0000000, 0, 1'b0);
      check("t4_b2b_data", resp_data, 128'hC00000C0_C00000C1_C00000C2_C00000C3);
      finish_resp();

      // 5: watchdog on the short-timeout instance; final-round beats arrive but no done.
      t_req_valid = 1'b1; t_req_mode = 2'b00;
      cycle();
      t_req_valid = 1'b0;
      check("t5_start", t_core_start, 1'b1);
      cycle();
      n = 0;
      t_core_round = 4'd10;
      while (!t_core_abort && n < 100) begin
         t_core_radix_sel = 2'(n);
         t_core_col_in    = 32'h12340000 + 32'(n);
         cycle();
         n++;
      end
      check("t5_abort_delay", n, 20);
      check("t5_valid", t_resp_valid, 1'b1);
      check("t5_err", t_resp_err, 1'b1);
      check("t5_data", t_resp_data, 128'd0);
      cycle();
      check("t5_abort_single", t_core_abort, 1'b0);
      t_resp_ready = 1'b1;
      cycle();
      t_resp_ready = 1'b0;
      check("t5_idle_ready", t_req_ready, 1'b1);

      // 6: reset in the middle of BUSY after some final-round columns were captured.
      req_valid = 1'b1; req_mode = 2'b00; req_enc_dec = 1'b1;
      cycle();
      req_valid = 1'b0;
      cycle();
      for (int b = 0; b < 4; b++) begin
         core_round     = 4'd10;
         core_radix_sel = 2'(b);
         core_col_in    = 32'h55550000 + 32'(b);
         cycle();
      end
      core_round = 4'd0; core_col_in = 32'd0;
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_req_ready", req_ready, 1'b1);
      check("t6_resp_valid", resp_valid, 1'b0);
      check("t6_resp_data", resp_data, 128'd0);
      check("t6_resp_err", resp_err, 1'b0);
      check("t6_round_amt", core_round_amount, 4'd0);
      check("t6_enc_dec", core_enc_dec, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (resp_valid) hi++;
      end
      check("t6_no_resp", hi, 0);
      check("t6_idle_ready", req_ready, 1'b1);

      check("main_no_abort", abort_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
